calc_op_sequencer: RTL and testbench

Sequencing controller between the calculator's operand switches / operation buttons and its iterative arithmetic units (adder, subtractor, divider, multiplier, square root, power). It accepts one operation request at a time, latches the operands, rejects illegal requests, issues a single-cycle start to the selected unit, waits for its done with a bounded timeout, and holds the captured result for the LED / BCD display path.

---
 rtl/calc_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_calc_op_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: accepts one arithmetic request at a time, validates it,
// pulses start to the selected unit, waits for done with a bounded timeout,
// and holds the captured result for the display path.
module calc_op_sequencer #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned RW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic [2:0]     op,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [2:0]     unit_sel,
  output logic [OPW-1:0] opa,
  output logic [OPW-1:0] opb,
  output logic           unit_start,
  input  logic           unit_done,
  input  logic [RW-1:0]  unit_result,
  output logic           busy,
  output logic [RW-1:0]  result,
  output logic           result_valid,
  output logic           err,
  output logic [1:0]     err_code
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_QUOT  = 3'd2;
  localparam logic [2:0] OP_REM   = 3'd4;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DIV0 = 2'd1;
  localparam logic [1:0] ERR_OPC  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      sel_nxt;
  logic [OPW-1:0]  opa_nxt, opb_nxt;
  logic            start_nxt, busy_nxt, valid_nxt, err_nxt;
  logic [RW-1:0]   result_nxt;
  logic [1:0]      code_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      unit_sel     <= '0;
      opa          <= '0;
      opb          <= '0;
      unit_start   <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      unit_sel     <= sel_nxt;
      opa          <= opa_nxt;
      opb          <= opb_nxt;
      unit_start   <= start_nxt;
      busy         <= busy_nxt;
      result       <= result_nxt;
      result_valid <= valid_nxt;
      err          <= err_nxt;
      err_code     <= code_nxt;
    end
  end

  // Next-state and next-output decode; unit_start is high exactly while in START
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sel_nxt    = unit_sel;
    opa_nxt    = opa;
    opb_nxt    = opb;
    start_nxt  = 1'b0;
    result_nxt = result;
    valid_nxt  = result_valid;
    err_nxt    = err;
    code_nxt   = err_code;

    unique case (state)
      S_IDLE: begin
        if (go) begin
          sel_nxt    = op;
          opa_nxt    = a;
          opb_nxt    = b;
          result_nxt = '0;
          valid_nxt  = 1'b0;
          err_nxt    = 1'b0;
          code_nxt   = ERR_NONE;
          state_nxt  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (unit_sel == OP_RSVD) begin
          err_nxt   = 1'b1;
          code_nxt  = ERR_OPC;
          state_nxt = S_IDLE;
        end else if (((unit_sel == OP_QUOT) || (unit_sel == OP_REM)) && (opb == '0)) begin
          err_nxt   = 1'b1;
          code_nxt  = ERR_DIV0;
          state_nxt = S_IDLE;
        end else begin
          start_nxt = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a coincident timeout
        if (unit_done) begin
          result_nxt = unit_result;
          valid_nxt  = 1'b1;
          state_nxt  = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          code_nxt  = ERR_TMO;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a result scoreboard.
module tb_calc_op_sequencer;

  localparam int unsigned OPW = 4;
  localparam int unsigned RW  = 8;
  localparam int unsigned TO  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           go;
  logic [2:0]     op;
  logic [OPW-1:0] a, b;
  logic [2:0]     unit_sel;
  logic [OPW-1:0] opa, opb;
  logic           unit_start;
  logic           unit_done;
  logic [RW-1:0]  unit_result;
  logic           busy;
  logic [RW-1:0]  result;
  logic           result_valid;
  logic           err;
  logic [1:0]     err_code;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          valid;
    logic          err;
    logic [1:0]    code;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   starts = 0;

  calc_op_sequencer #(.OPW(OPW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .op(op), .a(a), .b(b),
    .unit_sel(unit_sel), .opa(opa), .opb(opb), .unit_start(unit_start),
    .unit_done(unit_done), .unit_result(unit_result), .busy(busy),
    .result(result), .result_valid(result_valid), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Count start pulses seen at each rising edge
  always @(posedge clk) if (unit_start) starts++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".start"}, 32'(unit_start), 32'd0);
    chk({tag, ".sel"}, 32'(unit_sel), 32'd0);
    chk({tag, ".opa"}, 32'(opa), 32'd0);
    chk({tag, ".opb"}, 32'(opb), 32'd0);
    chk({tag, ".result"}, 32'(result), 32'd0);
    chk({tag, ".valid"}, 32'(result_valid), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".code"}, 32'(err_code), 32'd0);
  endtask

  // Drive one go pulse and check the accept-edge state
  task automatic do_go(input string tag, input logic [2:0] o, input logic [OPW-1:0] aa,
                       input logic [OPW-1:0] bb);
    go = 1'b1; op = o; a = aa; b = bb;
    tick();
    go = 1'b0;
    chk({tag, ".acc_busy"}, 32'(busy), 32'd1);
    chk({tag, ".acc_sel"}, 32'(unit_sel), 32'(o));
    chk({tag, ".acc_opa"}, 32'(opa), 32'(aa));
    chk({tag, ".acc_opb"}, 32'(opb), 32'(bb));
    chk({tag, ".acc_result"}, 32'(result), 32'd0);
    chk({tag, ".acc_valid"}, 32'(result_valid), 32'd0);
    chk({tag, ".acc_err"}, 32'(err), 32'd0);
    chk({tag, ".acc_start"}, 32'(unit_start), 32'd0);
  endtask

  // Pop the scoreboard and compare against the completed request
  task automatic complete(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".result"}, 32'(result), 32'(e.res));
      chk({tag, ".valid"}, 32'(result_valid), 32'(e.valid));
      chk({tag, ".err"}, 32'(err), 32'(e.err));
      chk({tag, ".code"}, 32'(err_code), 32'(e.code));
    end
  endtask

  initial begin
    int s0;
    rst_n = 1'b0; go = 1'b0; op = '0; a = '0; b = '0;
    unit_done = 1'b0; unit_result = '0;
    tick(); tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // add 9+6, done sampled three edges after the start edge
    s0 = starts;
    sb.push_back('{res: 8'd15, valid: 1'b1, err: 1'b0, code: 2'd0});
    do_go("add", 3'd0, 4'd9, 4'd6);
    tick();
    chk("add.start_hi", 32'(unit_start), 32'd1);
    tick();
    chk("add.start_lo", 32'(unit_start), 32'd0);
    chk("add.wait_busy", 32'(busy), 32'd1);
    tick();
    unit_done = 1'b1; unit_result = 8'd15;
    tick();
    unit_done = 1'b0; unit_result = '0;
    complete("add");
    chk("add.starts", 32'(starts - s0), 32'd1);

    // quotient by zero
    s0 = starts;
    sb.push_back('{res: 8'd0, valid: 1'b0, err: 1'b1, code: 2'd1});
    do_go("div0", 3'd2, 4'd7, 4'd0);
    tick();
    complete("div0");
    tick();
    chk("div0.starts", 32'(starts - s0), 32'd0);

    // reserved opcode, then a good multiply clears the error
    s0 = starts;
    sb.push_back('{res: 8'd0, valid: 1'b0, err: 1'b1, code: 2'd2});
    do_go("rsvd", 3'd7, 4'd1, 4'd1);
    tick();
    complete("rsvd");
    chk("rsvd.starts", 32'(starts - s0), 32'd0);
    sb.push_back('{res: 8'd15, valid: 1'b1, err: 1'b0, code: 2'd0});
    do_go("mul", 3'd3, 4'd3, 4'd5);
    tick(); tick(); tick();
    unit_done = 1'b1; unit_result = 8'd15;
    tick();
    unit_done = 1'b0;
    complete("mul");

    // power with no done: timeout after exactly TO wait cycles
    sb.push_back('{res: 8'd0, valid: 1'b0, err: 1'b1, code: 2'd3});
    do_go("tmo", 3'd6, 4'd2, 4'd3);
    tick(); tick();
    for (int i = 0; i < int'(TO) - 1; i++) begin
      tick();
      chk($sformatf("tmo.busy%0d", i), 32'(busy), 32'd1);
    end
    tick();
    complete("tmo");

    // rerun with done on the last wait cycle: done wins
    sb.push_back('{res: 8'hab, valid: 1'b1, err: 1'b0, code: 2'd0});
    do_go("tmo_done", 3'd6, 4'd2, 4'd3);
    tick(); tick();
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    unit_done = 1'b1; unit_result = 8'hab;
    tick();
    unit_done = 1'b0;
    complete("tmo_done");

    // go during WAIT is ignored; done in IDLE is ignored
    s0 = starts;
    sb.push_back('{res: 8'd5, valid: 1'b1, err: 1'b0, code: 2'd0});
    do_go("ign", 3'd1, 4'd8, 4'd3);
    tick(); tick();
    go = 1'b1; op = 3'd5; a = 4'd1; b = 4'd1;
    tick(); tick();
    go = 1'b0;
    chk("ign.opa", 32'(opa), 32'd8);
    chk("ign.opb", 32'(opb), 32'd3);
    chk("ign.sel", 32'(unit_sel), 32'd1);
    unit_done = 1'b1; unit_result = 8'd5;
    tick();
    unit_done = 1'b0;
    complete("ign");
    unit_done = 1'b1; unit_result = 8'd99;
    tick();
    unit_done = 1'b0;
    tick();
    chk("idle_done.result", 32'(result), 32'd5);
    chk("idle_done.valid", 32'(result_valid), 32'd1);
    chk("idle_done.busy", 32'(busy), 32'd0);
    chk("idle_done.starts", 32'(starts - s0), 32'd1);

    // async reset in the middle of WAIT, then a stray done
    do_go("rst", 3'd0, 4'd1, 4'd2);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check_reset("rst_async");
    tick();
    rst_n = 1'b1;
    unit_done = 1'b1; unit_result = 8'd77;
    tick();
    unit_done = 1'b0;
    tick();
    check_reset("rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
